// File: rtl/shift_unit_arbiter.sv
// ============================================================================
//  Module   : shift_unit_arbiter
//  Brief    : Round-robin arbiter/sequencer sharing one external 4-bit barrel
//             shifter among four requesters, with tagged valid/ready response.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module shift_unit_arbiter #(
  parameter int NREQ  = 4,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ-1:0]     req_select,
  input  logic [NREQ-1:0]     req_direction,
  input  logic [2*NREQ-1:0]   req_shift,
  input  logic [4*NREQ-1:0]   req_data,
  output logic                sh_select,
  output logic                sh_direction,
  output logic [1:0]          sh_shift_value,
  output logic [3:0]          sh_din,
  input  logic [3:0]          sh_dout,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [1:0]          resp_id,
  output logic [3:0]          resp_data,
  output logic [CNT_W-1:0]    op_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [1:0]       r_rr_ptr;
  logic [1:0]       w_winner;
  logic [1:0]       w_idx;
  logic             w_any;
  logic             w_grant;
  logic             w_resp_fire;

  logic             r_sh_select;
  logic             r_sh_direction;
  logic [1:0]       r_sh_shift_value;
  logic [3:0]       r_sh_din;
  logic             r_resp_valid;
  logic [1:0]       r_resp_id;
  logic [3:0]       r_resp_data;
  logic [CNT_W-1:0] r_op_count;

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    w_any    = 1'b0;
    w_winner = r_rr_ptr;
    w_idx    = r_rr_ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = r_rr_ptr + 2'(k);
      if (req_valid[w_idx]) begin
        w_any    = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  // rst_n gating keeps req_ready low while reset is held, even with requests pending.
  assign w_grant     = (r_state == ST_IDLE) && w_any && rst_n;
  assign w_resp_fire = (r_state == ST_RESP) && resp_ready;

  always_comb begin
    req_ready = '0;
    if (w_grant) begin
      req_ready = NREQ'(1) << w_winner;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_any) w_next_state = ST_ISSUE;
      ST_ISSUE: w_next_state = ST_RESP;
      ST_RESP:  if (resp_ready) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr         <= '0;
      r_sh_select      <= 1'b0;
      r_sh_direction   <= 1'b0;
      r_sh_shift_value <= '0;
      r_sh_din         <= '0;
      r_resp_valid     <= 1'b0;
      r_resp_id        <= '0;
      r_resp_data      <= '0;
      r_op_count       <= '0;
    end else begin
      if ((r_state == ST_IDLE) && w_any) begin
        r_sh_select      <= req_select[w_winner];
        r_sh_direction   <= req_direction[w_winner];
        r_sh_shift_value <= req_shift[{w_winner, 1'b0} +: 2];
        r_sh_din         <= req_data[{w_winner, 2'b00} +: 4];
        r_resp_id        <= w_winner;
        r_rr_ptr         <= w_winner + 2'd1;
      end
      if (r_state == ST_ISSUE) begin
        r_resp_data  <= sh_dout;
        r_resp_valid <= 1'b1;
      end
      if (w_resp_fire) begin
        r_resp_valid <= 1'b0;
        r_op_count   <= r_op_count + CNT_W'(1);
      end
    end
  end

  assign sh_select      = r_sh_select;
  assign sh_direction   = r_sh_direction;
  assign sh_shift_value = r_sh_shift_value;
  assign sh_din         = r_sh_din;
  assign resp_valid     = r_resp_valid;
  assign resp_id        = r_resp_id;
  assign resp_data      = r_resp_data;
  assign op_count       = r_op_count;

endmodule

`default_nettype wire
